// File: rtl/dma_copy_controller.sv
// Bus-mastering block copy engine: arbitrates for the system bus, then moves
// 32-bit words one read/write pair at a time, yielding the bus every BURST_LEN words.
module dma_copy_controller #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             dma_req,
  input  logic             dma_grant,
  output logic [31:0]      addr_out,
  output logic [31:0]      wdata_out,
  input  logic [31:0]      rdata_in,
  output logic             rd_out,
  output logic             wr_out,
  output logic [3:0]       mask_out,
  output logic             drive_en,
  input  logic             fc_bus
);

  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        src, src_nx, dst, dst_nx, data, data_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [BEAT_W-1:0]  beat, beat_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               busy_nx, done_nx, error_nx, dma_req_nx;
  logic               rd_nx, wr_nx, drive_nx;
  logic [31:0]        addr_nx, wdata_nx;
  logic [3:0]         mask_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src       <= 32'd0;
      dst       <= 32'd0;
      data      <= 32'd0;
      count     <= '0;
      beat      <= '0;
      timer     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      dma_req   <= 1'b0;
      addr_out  <= 32'd0;
      wdata_out <= 32'd0;
      rd_out    <= 1'b0;
      wr_out    <= 1'b0;
      mask_out  <= 4'h0;
      drive_en  <= 1'b0;
    end else begin
      state     <= state_nx;
      src       <= src_nx;
      dst       <= dst_nx;
      data      <= data_nx;
      count     <= count_nx;
      beat      <= beat_nx;
      timer     <= timer_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      error     <= error_nx;
      dma_req   <= dma_req_nx;
      addr_out  <= addr_nx;
      wdata_out <= wdata_nx;
      rd_out    <= rd_nx;
      wr_out    <= wr_nx;
      mask_out  <= mask_nx;
      drive_en  <= drive_nx;
    end
  end

  // Strobes rise one cycle into READ/WRITE; the timer only runs while a strobe waits for fc.
  always_comb begin
    state_nx   = state;
    src_nx     = src;
    dst_nx     = dst;
    data_nx    = data;
    count_nx   = count;
    beat_nx    = beat;
    timer_nx   = timer;
    busy_nx    = busy;
    done_nx    = 1'b0;
    error_nx   = 1'b0;
    dma_req_nx = 1'b0;
    addr_nx    = addr_out;
    wdata_nx   = wdata_out;
    rd_nx      = 1'b0;
    wr_nx      = 1'b0;
    drive_nx   = 1'b0;
    mask_nx    = 4'h0;

    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          src_nx   = src_addr & 32'hFFFF_FFFC;
          dst_nx   = dst_addr & 32'hFFFF_FFFC;
          count_nx = word_cnt;
          beat_nx  = '0;
          busy_nx  = 1'b1;
          state_nx = (word_cnt == '0) ? S_DONE : S_REQ;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_REQ: begin
        busy_nx    = 1'b1;
        dma_req_nx = 1'b1;
        // Only move once our own request is visible, so a tied-high grant cannot race it.
        if (dma_req && dma_grant) begin
          state_nx = S_READ;
          timer_nx = '0;
        end else begin
          state_nx = S_REQ;
        end
      end
      S_READ: begin
        busy_nx    = 1'b1;
        dma_req_nx = 1'b1;
        addr_nx    = src;
        if (rd_out && fc_bus) begin
          data_nx  = rdata_in;
          state_nx = S_WRITE;
          timer_nx = '0;
        end else if (!dma_grant) begin
          state_nx = S_ERROR;
        end else if (!rd_out) begin
          rd_nx = 1'b1;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nx = S_ERROR;
        end else begin
          rd_nx    = 1'b1;
          timer_nx = timer + 1'b1;
        end
      end
      S_WRITE: begin
        busy_nx    = 1'b1;
        dma_req_nx = 1'b1;
        addr_nx    = dst;
        wdata_nx   = data;
        if (wr_out && fc_bus) begin
          src_nx   = src + 32'd4;
          dst_nx   = dst + 32'd4;
          count_nx = count - 1'b1;
          timer_nx = '0;
          if (count == CNT_W'(1)) begin
            state_nx = S_DONE;
          end else if (beat == BEAT_W'(BURST_LEN - 1)) begin
            beat_nx  = '0;
            state_nx = S_RELEASE;
          end else begin
            beat_nx  = beat + 1'b1;
            state_nx = S_READ;
          end
        end else if (!dma_grant) begin
          state_nx = S_ERROR;
        end else if (!wr_out) begin
          wr_nx = 1'b1;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nx = S_ERROR;
        end else begin
          wr_nx    = 1'b1;
          timer_nx = timer + 1'b1;
        end
      end
      S_RELEASE: begin
        busy_nx  = 1'b1;
        state_nx = S_REQ;
      end
      S_DONE: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        count_nx = '0;
        state_nx = S_IDLE;
      end
      S_ERROR: begin
        error_nx = 1'b1;
        busy_nx  = 1'b0;
        count_nx = '0;
        beat_nx  = '0;
        state_nx = S_IDLE;
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase

    // The bus is driven only while staying inside the access states.
    if (((state == S_READ) || (state == S_WRITE)) &&
        ((state_nx == S_READ) || (state_nx == S_WRITE))) begin
      drive_nx = 1'b1;
      mask_nx  = 4'hF;
    end else begin
      drive_nx = 1'b0;
      mask_nx  = 4'h0;
    end
  end

endmodule

// File: tb/tb_dma_copy_controller.sv
// Randomized bench for dma_copy_controller: a bus slave/arbiter model drives the
// DUT and each copy is compared against addresses and data computed from the block rules.
module tb_dma_copy_controller;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src_addr, dst_addr, addr_out, wdata_out, rdata_in;
  logic [15:0] word_cnt;
  logic        busy, done, error, dma_req, dma_grant;
  logic        rd_out, wr_out, drive_en, fc_bus;
  logic [3:0]  mask_out;

  int checks = 0;
  int errors = 0;

  // slave / arbiter controls, written only by the main sequence
  int fc_lo = 0, fc_hi = 0, stall_at = -1, kill_at = -1, start_cyc = 0;

  // monitor state, written only by the monitor process
  int cyc = 0;
  int wait_cnt = 0, cur_delay = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, done_busy = 0;
  int rd_rise_cyc = 0, wr_rises = 0, str_rises = 0, req_cyc = 0, viol = 0;
  int kill_cyc = 0, kill_rises = 0, run = 0;
  bit kill_flag = 1'b0, seen_req = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0, busy_prev = 1'b0;
  logic [31:0] rd_a[$], wr_a[$], wr_d[$];
  int gaps[$];

  assign dma_grant = dma_req & ~kill_flag;

  dma_copy_controller #(.BURST_LEN(BL), .TIMEOUT(255), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .error(error), .dma_req(dma_req),
    .dma_grant(dma_grant), .addr_out(addr_out), .wdata_out(wdata_out), .rdata_in(rdata_in),
    .rd_out(rd_out), .wr_out(wr_out), .mask_out(mask_out), .drive_en(drive_en), .fc_bus(fc_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9E17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave with random fc latency plus bus observers, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      fc_bus   = 1'b0;
      wait_cnt = 0;
    end else if ((rd_out || wr_out) && !fc_bus) begin
      if (rd_out && rd_a.size() == stall_at) begin
        wait_cnt++;
      end else if (wait_cnt >= cur_delay) begin
        fc_bus = 1'b1;
        if (rd_out) begin
          rdata_in = pattern(addr_out);
          rd_a.push_back(addr_out);
        end else begin
          wr_a.push_back(addr_out);
          wr_d.push_back(wdata_out);
        end
        wait_cnt  = 0;
        cur_delay = $urandom_range(fc_hi, fc_lo);
      end else begin
        wait_cnt++;
      end
    end else begin
      fc_bus = 1'b0;
      if (!(rd_out || wr_out)) wait_cnt = 0;
    end

    if (rd_out && !rd_prev) begin rd_rise_cyc = cyc; str_rises++; end
    if (wr_out && !wr_prev) begin wr_rises++; str_rises++; end
    if (kill_at >= 0 && wr_rises >= kill_at) begin
      if (!kill_flag) begin kill_cyc = cyc; kill_rises = str_rises; end
      kill_flag = 1'b1;
    end else begin
      kill_flag = 1'b0;
    end
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = 32'({busy_prev, busy}); end
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (dma_req) req_cyc++;
    if ((rd_out || wr_out) && (mask_out != 4'hF || !drive_en)) viol++;
    if (!drive_en && mask_out != 4'h0) viol++;
    if (rd_out && wr_out) viol++;
    if (!busy) begin
      seen_req = 1'b0; run = 0;
    end else if (dma_req) begin
      if (seen_req && run > 0) gaps.push_back(run);
      seen_req = 1'b1; run = 0;
    end else if (seen_req) begin
      run++;
    end
    rd_prev = rd_out; wr_prev = wr_out; busy_prev = busy;
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr = s; dst_addr = d; word_cnt = 16'(n); start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int d0 = done_cnt;
    int e0 = err_cnt;
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk); #1;
      if (done_cnt != d0 || err_cnt != e0) hit = 1'b1;
    end
    if (!hit) chk("wait_budget", 32'd0, 32'd1);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    int rb = rd_a.size();
    int wb = wr_a.size();
    int db = done_cnt;
    int eb = err_cnt;
    int vb = viol;
    int gb = gaps.size();
    logic [31:0] ra, wa;
    kick(s, d, n);
    wait_end(60 * n + 100);
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt - db, 1);
    chk("no_error", err_cnt - eb, 0);
    chk("busy_falls_with_done", done_busy, 32'd2);
    chk("n_reads", rd_a.size() - rb, n);
    chk("n_writes", wr_a.size() - wb, n);
    for (int i = 0; i < n; i++) begin
      ra = (s & 32'hFFFF_FFFC) + 32'(4 * i);
      wa = (d & 32'hFFFF_FFFC) + 32'(4 * i);
      if (rb + i < rd_a.size()) chk("rd_addr", rd_a[rb + i], ra);
      if (wb + i < wr_a.size()) begin
        chk("wr_addr", wr_a[wb + i], wa);
        chk("wr_data", wr_d[wb + i], pattern(ra));
      end
    end
    chk("n_release_gaps", gaps.size() - gb, (n - 1) / BL);
    for (int g = gb; g < gaps.size(); g++) chk("gap_len", gaps[g], 32'd1);
    chk("strobe_rules", viol - vb, 0);
  endtask

  initial begin
    int db, eb, rq, sr;
    rst = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; word_cnt = 16'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_req", 32'(dma_req), 32'd0);
    chk("rst_addr", addr_out, 32'd0);
    chk("rst_wdata", wdata_out, 32'd0);
    chk("rst_strobes", 32'({rd_out, wr_out}), 32'd0);
    chk("rst_mask", 32'(mask_out), 32'd0);
    chk("rst_drive", 32'(drive_en), 32'd0);
    rst = 1'b0;

    // basic 3-word copy, slave answers one cycle into each strobe
    fc_lo = 1; fc_hi = 1;
    run_copy(32'h100, 32'h200, 3);

    // 10 words: bus released after words 4 and 8
    fc_lo = 0; fc_hi = 2;
    run_copy(32'h1000, 32'h2003, 10);

    // zero-length transfer
    db = done_cnt; rq = req_cyc;
    kick(32'h40, 32'h80, 0);
    wait_end(20);
    chk("zero_done", done_cnt - db, 1);
    chk("zero_done_latency", done_cyc - start_cyc, 2);
    chk("zero_no_req", req_cyc - rq, 0);

    // randomized copies
    for (int t = 0; t < 6; t++) begin
      fc_lo = 0; fc_hi = $urandom_range(3, 0);
      run_copy($urandom, $urandom, $urandom_range(12, 1));
    end

    // second read never completes -> timeout
    fc_lo = 0; fc_hi = 0;
    db = done_cnt; eb = err_cnt;
    stall_at = rd_a.size() + 1;
    kick(32'h300, 32'h400, 4);
    wait_end(400);
    chk("to_error", err_cnt - eb, 1);
    chk("to_latency", err_cyc - rd_rise_cyc, 256);
    chk("to_no_done", done_cnt - db, 0);
    chk("to_idle_out", 32'({rd_out, dma_req, busy}), 32'd0);
    stall_at = -1;

    // grant removed during the second write
    fc_lo = 2; fc_hi = 2;
    db = done_cnt; eb = err_cnt;
    kill_at = wr_rises + 2;
    kick(32'h800, 32'h900, 5);
    wait_end(100);
    repeat (5) @(negedge clk);
    #1;
    chk("lost_grant_error", err_cnt - eb, 1);
    chk("lost_grant_latency", err_cyc - kill_cyc, 2);
    chk("lost_grant_no_strobe", str_rises - kill_rises, 0);
    chk("lost_grant_no_done", done_cnt - db, 0);
    kill_at = -1;
    @(negedge clk);
    fc_lo = 0; fc_hi = 1;
    run_copy(32'hA00, 32'hB00, 2);

    // asynchronous reset in the middle of a read
    fc_lo = 3; fc_hi = 3;
    kick(32'h500, 32'h600, 3);
    for (int k = 0; k < 50 && !rd_out; k++) @(negedge clk);
    chk("rd_seen_before_rst", 32'(rd_out), 32'd1);
    sr = cyc;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_same_cycle", cyc - sr, 0);
    chk("async_rst_out", 32'({rd_out, dma_req, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fc_lo = 0; fc_hi = 1;
    run_copy(32'hFFFF_FFFC, 32'h700, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
